// File: rtl/data_axi_bridge_pkg.sv
// Shared definitions for the data-side AXI bridge: FSM encodings, AXI
// constants, the bridge ID and the kseg0/kseg1 address tag.
package data_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_BYTE   = 3'd0;
    localparam logic [2:0] SIZE_HALF   = 3'd1;
    localparam logic [2:0] SIZE_WORD   = 3'd2;
    localparam logic [3:0] DATA_AXI_ID = 4'd1;

    // kseg0 (3'b100) and kseg1 (3'b101) share the two top address bits 2'b10.
    localparam logic [1:0] KSEG01_TAG  = 2'b10;

    // Transfer size implied by a lane-aligned byte strobe.
    function automatic logic [2:0] size_from_strb(input logic [3:0] strb);
        logic [2:0] size;
        case (strb)
            4'b1111:          size = SIZE_WORD;
            4'b0011, 4'b1100: size = SIZE_HALF;
            default:          size = SIZE_BYTE;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/data_axi_bridge_axi_addr_map.sv
// Virtual-to-physical translation: kseg0/kseg1 fold onto the low 512 MiB,
// every other segment passes through unchanged.
module axi_addr_map
    import data_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] vaddr_i,
    output logic [ADDR_W-1:0] paddr_o
);

    // Clear the segment bits for unmapped kernel segments.
    always_comb begin
        paddr_o = vaddr_i;
        if (vaddr_i[ADDR_W-1 -: 2] == KSEG01_TAG) begin
            paddr_o[ADDR_W-1 -: 3] = 3'b000;
        end
    end

endmodule

// File: rtl/data_axi_bridge.sv
// Data-side memory port: turns one SRAM-style load/store into a single-beat
// AXI4 read or write and stalls the pipeline until it has completed.
//
// Handshakes: a channel transfers on a rising clk edge where valid and ready
// are both high; arvalid/awvalid/wvalid stay high from assertion until that
// edge, independent of flush, stall or the slave's ready.
module data_axi_bridge
    import data_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = DATA_AXI_ID,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic              stallreq,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [2:0]        dbg_state_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wen_q, wen_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] paddr_map;
    logic              aw_ok, w_ok;
    logic              unused_resp;

    // Responses are not checked; an error beat is treated like OKAY.
    assign unused_resp = ^{rresp, rlast, bresp};

    axi_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
        .vaddr_i (data_sram_addr),
        .paddr_o (paddr_map)
    );

    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign wlast   = 1'b1;
    // Loads are always word reads; the MEM stage picks bytes/halves itself.
    assign araddr  = {paddr_q[ADDR_W-1:2], 2'b00};
    assign arsize  = SIZE_WORD;
    assign awaddr  = paddr_q;
    assign awsize  = size_from_strb(wen_q);
    assign wdata   = wdata_q;
    assign wstrb   = wen_q;
    assign data_sram_rdata = rdata_q;
    assign dbg_state_o     = state_q;

    // State and captured-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            wdata_q   <= '0;
            wen_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state logic and AXI/stall outputs.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        wdata_d   = wdata_q;
        wen_d     = wen_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        stallreq  = 1'b0;
        aw_ok     = 1'b0;
        w_ok      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (data_sram_en && !flush) begin
                    stallreq = 1'b1;
                    paddr_d  = paddr_map;
                    wdata_d  = data_sram_wdata;
                    wen_d    = data_sram_wen;
                    state_d  = (data_sram_wen == 4'b0000) ? ST_RADDR : ST_WREQ;
                end
            end
            ST_RADDR: begin
                stallreq = 1'b1;
                arvalid  = 1'b1;
                if (arready) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                stallreq = 1'b1;
                rready   = 1'b1;
                if (rvalid) begin
                    rdata_d = rdata;
                    state_d = ST_DONE;
                end
            end
            ST_WREQ: begin
                stallreq = 1'b1;
                awvalid  = !aw_done_q;
                wvalid   = !w_done_q;
                aw_ok    = aw_done_q || awready;
                w_ok     = w_done_q || wready;
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WRESP;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end
            ST_WRESP: begin
                stallreq = 1'b1;
                bready   = 1'b1;
                if (bvalid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_axi_bridge.sv
// Bench for data_axi_bridge: a word-addressed memory model behind a simple
// AXI slave with per-transaction random delays.
module tb_data_axi_bridge;
    import data_axi_bridge_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        flush, data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        stallreq;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, dbg_state;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    data_axi_bridge dut (
        .clk(clk), .rst(rst), .flush(flush),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_rdata;
    logic [31:0] mem [int unsigned];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // kseg0 and kseg1 are each a 512 MiB window onto physical 0.
    function automatic logic [31:0] v2p(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a % 32'h2000_0000;
        return a;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] pa);
        int unsigned k = pa / 4;
        if (!mem.exists(k)) mem[k] = $urandom;
        return mem[k];
    endfunction

    task automatic mem_wr(input logic [31:0] pa, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m = mem_rd(pa);
        for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = d[b*8 +: 8];
        mem[pa / 4] = m;
    endtask

    function automatic logic [2:0] exp_size(input logic [3:0] be);
        int n = $countones(be);
        return (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One request; returns during its DONE cycle. b2b: called during the
    // previous request's DONE cycle, so the request must wait for IDLE.
    task automatic run_txn(input logic [31:0] va, input logic [3:0] be, input logic [31:0] wd,
                           input int a_dly, input int w_dly, input int r_dly,
                           input bit fl, input bit b2b, input bit chk_lat);
        logic [31:0] pa = v2p(va);
        bit is_rd = (be == 4'b0000);
        int ar_n = 0, aw_n = 0, w_n = 0, stall_n = 0, hs_c = 0;
        bit fin = 0;
        data_sram_en = 1'b1; data_sram_wen = be; data_sram_addr = va;
        data_sram_wdata = wd; flush = 1'b0;
        if (is_rd) exp_q.push_back(mem_rd(pa));
        #1;
        if (b2b) begin
            check("b2b_done_nostall", stallreq, 0);
            check("b2b_done_state", dbg_state, ST_DONE);
            idle(1);
        end
        check("accept_state", dbg_state, ST_IDLE);
        check("accept_stall", stallreq, 1);
        stall_n = 1;
        @(negedge clk);
        data_sram_en = 1'b0; data_sram_wen = 4'b0000;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (is_rd) begin
                arready = (c >= a_dly);
                rvalid  = (ar_n > 0) && (c >= hs_c + 1 + r_dly);
                rdata   = rvalid ? exp_q[0] : $urandom;
                awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
                flush   = fl && (ar_n > 0);
            end else begin
                awready = (c >= a_dly);
                wready  = (c >= w_dly);
                bvalid  = (aw_n > 0) && (w_n > 0) && (c >= hs_c + 1 + r_dly);
                arready = 1'b1; rvalid = 1'b0;
            end
            #1;
            stall_n += int'(stallreq);
            check("busy_stall", stallreq, 1);
            if (is_rd) begin
                check("arvalid_hold", arvalid, ar_n == 0);
                if (ar_n == 0) begin
                    check("araddr", araddr, pa & 32'hFFFF_FFFC);
                    check("arsize", arsize, 3'd2);
                end else begin
                    check("rready", rready, 1);
                end
            end else begin
                check("awvalid_hold", awvalid, aw_n == 0);
                check("wvalid_hold", wvalid, w_n == 0);
                if (aw_n == 0) begin
                    check("awaddr", awaddr, pa);
                    check("awsize", awsize, exp_size(be));
                end
                if (w_n == 0) begin
                    check("wstrb", wstrb, be);
                    check("wdata", wdata, wd);
                end
                if (aw_n > 0 && w_n > 0) check("bready", bready, 1);
            end
            if (arvalid && arready) begin ar_n++; hs_c = c; end
            if (!is_rd && (aw_n == 0 || w_n == 0)) begin
                if (awvalid && awready) aw_n++;
                if (wvalid && wready) w_n++;
                if (aw_n > 0 && w_n > 0) hs_c = c;
            end else begin
                if (awvalid && awready) aw_n++;
                if (wvalid && wready) w_n++;
            end
            if ((rvalid && rready) || (bvalid && bready)) fin = 1;
            @(negedge clk);
        end
        rvalid = 1'b0; bvalid = 1'b0; arready = 1'b0; awready = 1'b0;
        wready = 1'b0; flush = 1'b0;
        #1;
        if (!fin) check("timeout", 0, 1);
        if (is_rd) exp_rdata = exp_q.pop_front();
        else mem_wr(pa, wd, be);
        check("done_stall", stallreq, 0);
        check("done_rdata", data_sram_rdata, exp_rdata);
        check("done_valids", {29'd0, arvalid, awvalid, wvalid}, 0);
        check("ar_count", ar_n, is_rd ? 1 : 0);
        check("aw_count", aw_n, is_rd ? 0 : 1);
        check("w_count", w_n, is_rd ? 0 : 1);
        if (chk_lat) check("stall_cycles", stall_n, 3);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]  be_tab [7];
    logic [3:0]  seg_tab [6];

    initial begin
        be_tab  = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        seg_tab = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hB};
        rst = 1'b1; flush = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'b0000;
        data_sram_addr = '0; data_sram_wdata = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
        bresp = 2'b00; bvalid = 1'b0;
        exp_rdata = '0;
        idle(3);
        check("rst_stall", stallreq, 0);
        check("rst_valids", {29'd0, arvalid, awvalid, wvalid}, 0);
        check("rst_readys", {30'd0, rready, bready}, 0);
        check("rst_rdata", data_sram_rdata, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("tied", {arlen, awlen, arburst, awburst, wlast, 3'b0}, {8'd0, 8'd0, 2'b01, 2'b01, 1'b1, 3'b0});
        check("ids", {arid, awid, wid}, {4'd1, 4'd1, 4'd1});
        rst = 1'b0;
        idle(1);

        // zero-wait load through kseg0
        mem[32'h1FC0_0004 / 4] = 32'hDEAD_BEEF;
        run_txn(32'h9FC0_0004, 4'b0000, 32'h0, 0, 0, 0, 0, 0, 1);
        check("lw_deadbeef", data_sram_rdata, 32'hDEAD_BEEF);
        idle(1);
        // zero-wait byte store through kseg1
        run_txn(32'hA000_0012, 4'b0100, 32'h00AB_0000, 0, 0, 0, 0, 0, 1);
        idle(1);
        // W accepted three cycles before AW
        run_txn(32'h8000_0020, 4'b1111, $urandom, 3, 0, 1, 0, 0, 0);
        idle(1);
        // load immediately followed by store
        run_txn(32'h0000_0020, 4'b0000, 32'h0, 1, 0, 0, 0, 0, 0);
        run_txn(32'h0000_0024, 4'b0011, $urandom, 0, 2, 0, 0, 1, 0);
        idle(1);
        // flush during a slow R beat, then a flushed request in IDLE
        run_txn(32'h8000_0020, 4'b0000, 32'h0, 0, 0, 5, 1, 0, 0);
        idle(1);
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_0040;
        flush = 1'b1;
        #1;
        check("flush_idle_stall", stallreq, 0);
        idle(1);
        check("flush_idle_state", dbg_state, ST_IDLE);
        check("flush_idle_noar", arvalid, 0);
        data_sram_en = 1'b0; flush = 1'b0;
        idle(1);

        // random traffic; kseg0/kseg1/physical aliases share the model memory
        for (int i = 0; i < 24; i++) begin
            logic [31:0] va;
            logic [3:0]  be;
            bit          b2b;
            b2b = (i > 0) ? bit'($urandom_range(0, 1)) : 1'b0;
            if (!b2b && i > 0) idle(1);
            va = {seg_tab[$urandom_range(0, 5)], 28'h0} | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            be = ($urandom_range(0, 1) == 0) ? 4'b0000 : be_tab[$urandom_range(0, 6)];
            run_txn(va, be, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), 0, b2b, 0);
        end
        idle(1);

        // reset while a store is in WREQ
        data_sram_en = 1'b1; data_sram_wen = 4'b1111; data_sram_addr = 32'h0000_0100;
        data_sram_wdata = $urandom; awready = 1'b0; wready = 1'b0;
        idle(1);
        data_sram_en = 1'b0;
        check("wreq_awvalid", awvalid, 1);
        rst = 1'b1;
        idle(1);
        check("rst_mid_state", dbg_state, ST_IDLE);
        check("rst_mid_valids", {30'd0, awvalid, wvalid}, 0);
        check("rst_mid_stall", stallreq, 0);
        check("rst_mid_rdata", data_sram_rdata, 0);
        rst = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
